// File: rtl/composite_timing_gen.sv
// Single-clock composite video timing generator: pixel-rate enable, H/V counters,
// broad-pulse vsync, one-line-ahead fetch handshake and 3-bit level mux.
// Define TEST_PATTERN_EN to add the internal colour-bar source selected by test_mode.
module composite_timing_gen #(
    parameter int CLK_DIV        = 10,
    parameter int H_TOTAL        = 384,
    parameter int H_SYNC         = 28,
    parameter int H_ACTIVE_START = 64,
    parameter int H_ACTIVE       = 256,
    parameter int V_TOTAL        = 262,
    parameter int V_SYNC_LINES   = 3,
    parameter int V_ACTIVE_START = 40,
    parameter int V_ACTIVE       = 192
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [2:0] pix_in,
    input  logic       line_ack,
    input  logic       test_mode,
    output logic       pix_tick,
    output logic [8:0] pix_x,
    output logic [7:0] pix_y,
    output logic       pix_valid,
    output logic       row_enable,
    output logic       vblank,
    output logic       line_req,
    output logic [7:0] line_idx,
    output logic       underrun,
    output logic [2:0] sig
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [DW-1:0] div;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [31:0]   hc, vc;
    logic          tick, line_act, broad, h_act, h_req, fetch_line, no_fetch;
    logic [2:0]    pix_lvl, pix_clamp;

    assign tick       = (div == DW'(CLK_DIV - 1));
    assign hc         = 32'(hcnt);
    assign vc         = 32'(vcnt);
    assign line_act   = (vc >= V_ACTIVE_START) && (vc < V_ACTIVE_START + V_ACTIVE);
    assign broad      = (vc < V_SYNC_LINES);
    assign h_act      = (hc >= H_ACTIVE_START) && (hc < H_ACTIVE_START + H_ACTIVE);
    // Requests lead the displayed pixel by one tick to cover the pix_in latency.
    assign h_req      = (hc >= H_ACTIVE_START - 1) && (hc < H_ACTIVE_START + H_ACTIVE - 1);
    assign fetch_line = (vc >= V_ACTIVE_START - 1) && (vc < V_ACTIVE_START - 1 + V_ACTIVE);

`ifdef TEST_PATTERN_EN
    logic [2:0] bar;
    assign bar      = 3'(pix_x[8:5] % 4'd7);
    assign pix_lvl  = test_mode ? (bar + 3'd1) : pix_in;
    assign no_fetch = test_mode;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign pix_lvl  = pix_in;
    assign no_fetch = 1'b0;
`endif

    // Level 0 is reserved for sync, so picture data never goes below black.
    assign pix_clamp = (pix_lvl == 3'd0) ? 3'd1 : pix_lvl;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div        <= '0;
            hcnt       <= '0;
            vcnt       <= '0;
            pix_tick   <= 1'b0;
            pix_x      <= 9'd0;
            pix_y      <= 8'd0;
            pix_valid  <= 1'b0;
            row_enable <= 1'b0;
            vblank     <= 1'b0;
            line_req   <= 1'b0;
            line_idx   <= 8'd0;
            underrun   <= 1'b0;
            sig        <= 3'd1;
        end else begin
            pix_tick <= (div == DW'(CLK_DIV - 2));
            div      <= tick ? '0 : div + DW'(1);
            if (line_req && line_ack)
                line_req <= 1'b0;
            if (no_fetch)
                line_req <= 1'b0;
            if (tick) begin
                if (hc == H_TOTAL - 1) begin
                    hcnt <= '0;
                    vcnt <= (vc == V_TOTAL - 1) ? '0 : vcnt + VW'(1);
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
                pix_valid  <= line_act && h_req;
                pix_x      <= (line_act && h_req) ? 9'(hc - 32'(H_ACTIVE_START - 1)) : 9'd0;
                pix_y      <= line_act ? 8'(vc - 32'(V_ACTIVE_START)) : 8'd0;
                row_enable <= line_act && h_act;
                vblank     <= !line_act;
                if (broad)
                    sig <= (hc < H_TOTAL - H_SYNC) ? 3'd0 : 3'd1;
                else if (hc < H_SYNC)
                    sig <= 3'd0;
                else if (line_act && h_act)
                    sig <= pix_clamp;
                else
                    sig <= 3'd1;
                // A fresh request overrides an ack landing on the same edge.
                if (!no_fetch && hc == 0 && fetch_line) begin
                    line_req <= 1'b1;
                    line_idx <= 8'(vc - 32'(V_ACTIVE_START - 1));
                end
                if (!no_fetch && line_act && hc == H_ACTIVE_START && line_req)
                    underrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_composite_timing_gen.sv
// Bench for composite_timing_gen with shrunken timing; pixel levels go through a scoreboard queue.
module tb_composite_timing_gen;
    localparam int CD  = 3;
    localparam int HT  = 300;
    localparam int HS  = 4;
    localparam int HAS = 8;
    localparam int HA  = 256;
    localparam int VT  = 12;
    localparam int VS  = 3;
    localparam int VAS = 5;
    localparam int VA  = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] pix_in = 3'd0;
    logic       line_ack = 1'b0;
    logic       test_mode = 1'b0;
    logic       pix_tick, pix_valid, row_enable, vblank, line_req, underrun;
    logic [8:0] pix_x;
    logic [7:0] pix_y, line_idx;
    logic [2:0] sig;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mh = -1, mv = -1, nh = 0, nv = 0;
    logic [2:0] exp_q[$];

    composite_timing_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE_START(HAS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC_LINES(VS), .V_ACTIVE_START(VAS), .V_ACTIVE(VA)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_in(pix_in), .line_ack(line_ack),
        .test_mode(test_mode), .pix_tick(pix_tick), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .row_enable(row_enable), .vblank(vblank),
        .line_req(line_req), .line_idx(line_idx), .underrun(underrun), .sig(sig)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to the next pixel tick; afterwards outputs show position (mh, mv).
    task automatic step_tick();
        int n = 0;
        while (pix_tick !== 1'b1 && n < 4 * CD) begin
            @(posedge sys_clk); #1; n++;
        end
        tests++;
        if (pix_tick !== 1'b1) begin
            $display("FAIL tick_timeout: got pix_tick=%b expected 1 within %0d cycles", pix_tick, 4 * CD);
            fails++;
        end
        @(posedge sys_clk); #1;
        mh = nh; mv = nv;
        if (nh == HT - 1) begin
            nh = 0;
            nv = (nv == VT - 1) ? 0 : nv + 1;
        end else begin
            nh++;
        end
    endtask

    task automatic goto(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 2 * HT * VT) begin
            step_tick(); n++;
        end
        tests++;
        if (!(mh == h && mv == v)) begin
            $display("FAIL goto: reached (%0d,%0d) expected (%0d,%0d)", mh, mv, h, v);
            fails++;
        end
    endtask

    task automatic wait_first_tick(input string name);
        int n = 1;
        while (pix_tick !== 1'b1 && n < 4 * CD) begin
            @(posedge sys_clk); #1; n++;
        end
        tests++;
        if (n != CD) begin
            $display("FAIL %s: first pix_tick at cycle %0d expected %0d", name, n, CD);
            fails++;
        end
        tests++;
        if (sig !== 3'd1) begin
            $display("FAIL %s_sig: got %0d expected 1 before first tick", name, sig);
            fails++;
        end
        nh = 0; nv = 0; mh = -1; mv = -1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        tests++;
        if ({pix_tick, pix_valid, row_enable, vblank, line_req, underrun} !== 6'b0 ||
            pix_x !== 9'd0 || pix_y !== 8'd0 || line_idx !== 8'd0) begin
            $display("FAIL reset_outputs: got flags=%b x=%0d y=%0d idx=%0d expected all 0",
                     {pix_tick, pix_valid, row_enable, vblank, line_req, underrun}, pix_x, pix_y, line_idx);
            fails++;
        end
        tests++;
        if (sig !== 3'd1) begin
            $display("FAIL reset_sig: got %0d expected 1", sig);
            fails++;
        end
        sys_rst = 1'b0;
        wait_first_tick("reset_first_tick");
        step_tick();
        tests++;
        if (sig !== 3'd0 || vblank !== 1'b1) begin
            $display("FAIL reset_line0: got sig=%0d vblank=%b expected sig=0 vblank=1", sig, vblank);
            fails++;
        end
    endtask

    task automatic test_fetch();
        int n;
        goto(HT - 1, VAS - 2);
        tests++;
        if (line_req !== 1'b0) begin
            $display("FAIL fetch_idle: got line_req=%b expected 0", line_req);
            fails++;
        end
        step_tick();
        tests++;
        if (line_req !== 1'b1 || line_idx !== 8'd0) begin
            $display("FAIL fetch_req0: got req=%b idx=%0d expected req=1 idx=0", line_req, line_idx);
            fails++;
        end
        repeat (50) step_tick();
        tests++;
        if (line_req !== 1'b1) begin
            $display("FAIL fetch_hold: got line_req=%b expected 1", line_req);
            fails++;
        end
        line_ack = 1'b1;
        @(posedge sys_clk); #1;
        tests++;
        if (line_req !== 1'b0) begin
            $display("FAIL fetch_ack_clear: got line_req=%b expected 0", line_req);
            fails++;
        end
        @(posedge sys_clk); #1;
        tests++;
        if (line_req !== 1'b0) begin
            $display("FAIL fetch_ack_idle: got line_req=%b expected 0", line_req);
            fails++;
        end
        line_ack = 1'b0;
        goto(0, VAS);
        tests++;
        if (line_req !== 1'b1 || line_idx !== 8'd1 || underrun !== 1'b0) begin
            $display("FAIL fetch_req1: got req=%b idx=%0d und=%b expected req=1 idx=1 und=0",
                     line_req, line_idx, underrun);
            fails++;
        end
        goto(HAS - 1, VAS);
        tests++;
        if (underrun !== 1'b0) begin
            $display("FAIL underrun_early: got %b expected 0", underrun);
            fails++;
        end
        step_tick();
        tests++;
        if (underrun !== 1'b1) begin
            $display("FAIL underrun_set: got %b expected 1", underrun);
            fails++;
        end
        goto(HT - 1, VAS);
        tests++;
        if (underrun !== 1'b1) begin
            $display("FAIL underrun_sticky: got %b expected 1", underrun);
            fails++;
        end
        // Ack coinciding with the next request edge: the new request must survive.
        n = 0;
        while (pix_tick !== 1'b1 && n < 4 * CD) begin
            @(posedge sys_clk); #1; n++;
        end
        line_ack = 1'b1;
        step_tick();
        line_ack = 1'b0;
        tests++;
        if (line_req !== 1'b1 || line_idx !== 8'd2) begin
            $display("FAIL fetch_new_wins: got req=%b idx=%0d expected req=1 idx=2", line_req, line_idx);
            fails++;
        end
    endtask

    task automatic test_pixels();
        logic pv, re;
        logic [2:0] e;
        int k;
        exp_q.delete();
        goto(HT - 1, VAS + 1);
        for (int i = 0; i < HT; i++) begin
            step_tick();
            pv = (mh >= HAS - 1) && (mh <= HAS + HA - 2);
            re = (mh >= HAS) && (mh < HAS + HA);
            tests++;
            if (pix_valid !== pv || row_enable !== re) begin
                $display("FAIL pix_window h=%0d: got valid=%b row=%b expected valid=%b row=%b",
                         mh, pix_valid, row_enable, pv, re);
                fails++;
            end
            if (re) begin
                tests++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pix_queue h=%0d: got empty queue expected a pending pixel", mh);
                    fails++;
                end else begin
                    e = exp_q.pop_front();
                    if (sig !== e) begin
                        $display("FAIL pix_level h=%0d: got %0d expected %0d", mh, sig, e);
                        fails++;
                    end
                end
            end else begin
                e = (mh < HS) ? 3'd0 : 3'd1;
                tests++;
                if (sig !== e) begin
                    $display("FAIL pix_blank h=%0d: got %0d expected %0d", mh, sig, e);
                    fails++;
                end
            end
            if (pv) begin
                k = mh - (HAS - 1);
                tests++;
                if (pix_x !== 9'(k) || pix_y !== 8'(2)) begin
                    $display("FAIL pix_addr h=%0d: got x=%0d y=%0d expected x=%0d y=2", mh, pix_x, pix_y, k);
                    fails++;
                end
                pix_in = 3'(k % 8);
                exp_q.push_back((pix_in == 3'd0) ? 3'd1 : pix_in);
            end
        end
        pix_in = 3'd0;
        tests++;
        if (exp_q.size() != 0 || vblank !== 1'b0) begin
            $display("FAIL pix_drain: got %0d left vblank=%b expected 0 left vblank=0", exp_q.size(), vblank);
            fails++;
        end
    endtask

    task automatic test_hsync();
        int c0;
        logic [2:0] e;
        goto(HT - 1, 9);
        step_tick();
        c0 = cyc;
        tests++;
        if (sig !== 3'd0 || vblank !== 1'b1) begin
            $display("FAIL hsync_start: got sig=%0d vblank=%b expected sig=0 vblank=1", sig, vblank);
            fails++;
        end
        for (int i = 1; i < HT; i++) begin
            step_tick();
            e = (mh < HS) ? 3'd0 : 3'd1;
            tests++;
            if (sig !== e || row_enable !== 1'b0) begin
                $display("FAIL hsync_line h=%0d: got sig=%0d row=%b expected sig=%0d row=0", mh, sig, row_enable, e);
                fails++;
            end
        end
        step_tick();
        tests++;
        if (cyc - c0 != HT * CD) begin
            $display("FAIL line_period: got %0d cycles expected %0d", cyc - c0, HT * CD);
            fails++;
        end
    endtask

    task automatic test_broad();
        logic [2:0] e;
        goto(HT - 1, VT - 1);
        for (int ln = 0; ln <= VS; ln++) begin
            for (int i = 0; i < HT; i++) begin
                step_tick();
                if (ln < VS) e = (mh < HT - HS) ? 3'd0 : 3'd1;
                else         e = (mh < HS) ? 3'd0 : 3'd1;
                tests++;
                if (sig !== e || vblank !== 1'b1) begin
                    $display("FAIL broad v=%0d h=%0d: got sig=%0d vblank=%b expected sig=%0d vblank=1",
                             ln, mh, sig, vblank, e);
                    fails++;
                end
            end
        end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        logic [2:0] e;
        int k;
        goto(HT - 1, VAS + 1);
        test_mode = 1'b1;
        for (int i = 0; i < HT; i++) begin
            step_tick();
            tests++;
            if (line_req !== 1'b0) begin
                $display("FAIL pattern_req h=%0d: got %b expected 0", mh, line_req);
                fails++;
            end
            if (mh >= HAS && mh < HAS + HA) begin
                k = mh - HAS;
                e = 3'(1 + ((k >> 5) % 7));
                tests++;
                if (sig !== e) begin
                    $display("FAIL pattern_bar h=%0d: got %0d expected %0d", mh, sig, e);
                    fails++;
                end
            end
        end
        test_mode = 1'b0;
    endtask
`endif

    task automatic test_reset_midline();
        goto(20, VAS + 3);
        tests++;
        if (underrun !== 1'b1 || row_enable !== 1'b1) begin
            $display("FAIL midreset_pre: got und=%b row=%b expected und=1 row=1", underrun, row_enable);
            fails++;
        end
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        tests++;
        if ({pix_tick, pix_valid, row_enable, vblank, line_req, underrun} !== 6'b0 ||
            pix_x !== 9'd0 || pix_y !== 8'd0 || line_idx !== 8'd0 || sig !== 3'd1) begin
            $display("FAIL midreset_state: got flags=%b x=%0d y=%0d idx=%0d sig=%0d expected 0s and sig=1",
                     {pix_tick, pix_valid, row_enable, vblank, line_req, underrun}, pix_x, pix_y, line_idx, sig);
            fails++;
        end
        wait_first_tick("midreset_first_tick");
        step_tick();
        tests++;
        if (sig !== 3'd0 || vblank !== 1'b1) begin
            $display("FAIL midreset_line0: got sig=%0d vblank=%b expected sig=0 vblank=1", sig, vblank);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_pixels();
        test_hsync();
        test_broad();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
